display_timing_gen: RTL and testbench
=====================================

Name: display_timing_gen

Overview:
- Parametrised raster timing generator for the display pipeline. Generalises the fixed 640x480p60 generator.
- Horizontal and vertical timings, sync polarities and the pixel-clock divide ratio are all parameters.
- An internal pixel-enable divider lets the block run directly from the board clock, e.g. 100 MHz with PIX_DIV=4 gives a 25 MHz pixel rate.
- Adds per-pixel strobe and line-start/frame-start outputs so that downstream sprite/text renderers can synchronise without decoding coordinates.

Parameters:
- CORDW, 10, width of sx/sy counters; must hold H_TOTAL-1 and V_TOTAL-1.
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_RES, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- H_POL, 0, hsync active level (0 = negative, 1 = positive).
- V_POL, 0, vsync active level.
- PIX_DIV, 1, clk_pix cycles per pixel; 1..16.

Ports:
- clk_pix  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- sx  output  CORDW  horizontal position, 0..H_TOTAL-1.
- sy  output  CORDW  vertical position, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, polarity per H_POL.
- vsync  output  1  vertical sync, polarity per V_POL.
- de  output  1  data enable; high in the active region.
- pix_en  output  1  one-cycle strobe on the last clk_pix cycle of each pixel period.
- line  output  1  high for the whole pixel period where sx==0.
- frame  output  1  high for the whole pixel period where sx==0 and sy==0.

Behaviour:
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
  - HS_STA = H_RES+H_FP; HS_END = HS_STA+H_SYNC-1 (inclusive).
  - VS_STA = V_RES+V_FP; VS_END = VS_STA+V_SYNC-1.
- Divider:
  - div counts 0..PIX_DIV-1 every clk_pix cycle and wraps.
  - pix_en = (div==PIX_DIV-1).
  - PIX_DIV=1 gives pix_en constantly high outside reset.
- Counters:
  - Advance only on edges where pix_en=1.
  - sx increments; at sx==H_TOTAL-1, sx wraps to 0 and sy advances.
  - sy wraps from V_TOTAL-1 to 0.
  - sx/sy therefore hold each value for exactly PIX_DIV cycles.
- Decoded outputs are all registered and aligned with the current sx/sy (zero skew between them):
  - de = (sx<H_RES && sy<V_RES).
  - hsync active iff HS_STA<=sx<=HS_END; vsync active iff VS_STA<=sy<=VS_END. Output level is the active level per polarity, else its inverse.
  - line = (sx==0); frame = (sx==0 && sy==0).
- Reset: on an edge with rst=1:
  - sx=0, sy=0, div=0.
  - de=0, line=0, frame=0, pix_en=0.
  - hsync=~H_POL, vsync=~V_POL (inactive).
- Reset release:
  - The first edge with rst=0 starts pixel (0,0), so de=1, line=1, frame=1 are visible from that edge.
  - That pixel period lasts PIX_DIV cycles.
  - pix_en first asserts PIX_DIV-1 cycles after that edge.
- Reset mid-frame: takes effect on the next edge regardless of div or position. There is no partial-line completion.
- Frame length: exactly H_TOTAL*V_TOTAL*PIX_DIV clk_pix cycles between consecutive frame rising edges.
- Sync occupancy:
  - hsync active for exactly H_SYNC pixel periods per line, on every line including vertical blanking.
  - vsync active for V_SYNC full lines, with transitions coincident with sx==0.
- Widths: comparisons are unsigned at CORDW. Parameter sets that overflow CORDW are illegal. The testbench checks this at elaboration.
- Defaults reproduce standard 640x480p60: 800x525 total, negative syncs.

Test Plan:
- Defaults, PIX_DIV=1, 2 frames:
  - Line period 800 cycles.
  - hsync low exactly at sx 656..751.
  - vsync low at sy 490..491.
  - 640*480 de cycles per frame; frame period 420000 cycles.
- Small mode (H 8/2/3/1, V 4/1/1/1, positive polarity, PIX_DIV=1):
  - sx wraps 13->0; sy wraps 6->0.
  - hsync high at sx 10..12; vsync high only at sy 5.
  - frame every 98 cycles.
- Small mode with PIX_DIV=4:
  - Each sx value held 4 cycles.
  - pix_en high 1 of 4 cycles, on the last cycle of each sx.
  - frame high for 4 cycles every 392 cycles.
- Reset release: hold rst 5 cycles.
  - During reset: sx=sy=0, de=line=frame=pix_en=0, syncs inactive.
  - First edge after release: de=line=frame=1.
  - PIX_DIV=4: first pix_en 3 cycles later.
- Reset mid-frame at sx=11, sy=5 (hsync and vsync active, small mode):
  - Next edge: sx=0, sy=0, syncs inactive, de=0.
  - Resumes correctly on release.
- Checker across all configs:
  - line coincides with sx==0; frame implies line.
  - de never high while hsync or vsync is active.

Source files
------------

// File: rtl/display_timing_gen.sv
// display_timing_gen: parametrised raster timing generator.
// A pixel-enable divider lets the block run from a fast board clock; sx/sy
// advance once per pixel period and every decoded output is registered from
// the next-state position, so all outputs line up with sx/sy.
module display_timing_gen #(
  parameter int CORDW   = 10,
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int PIX_DIV = 1
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             pix_en,
  output logic             line,
  output logic             frame
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HS_STA  = H_RES + H_FP;
  localparam int HS_END  = HS_STA + H_SYNC - 1;
  localparam int VS_STA  = V_RES + V_FP;
  localparam int VS_END  = VS_STA + V_SYNC - 1;

  localparam int DIVW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PIX_DIV - 1);

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_LO  = CORDW'(HS_STA);
  localparam logic [CORDW-1:0] HS_HI  = CORDW'(HS_END);
  localparam logic [CORDW-1:0] VS_LO  = CORDW'(VS_STA);
  localparam logic [CORDW-1:0] VS_HI  = CORDW'(VS_END);
  localparam logic HP = (H_POL != 0);
  localparam logic VP = (V_POL != 0);

  // run_q is low only for the reset state, so the first edge after release
  // enters pixel (0,0) instead of advancing past it.
  logic             run_q;
  logic [DIVW-1:0]  div_q, div_d;
  logic [CORDW-1:0] sx_q, sy_q, sx_d, sy_d;
  logic             hsync_q, vsync_q, de_q, pix_en_q, line_q, frame_q;
  logic             hs_act_d, vs_act_d;

  // Next divider phase and raster position.
  always_comb begin
    div_d = div_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    if (!run_q) begin
      div_d = '0;
      sx_d  = '0;
      sy_d  = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);
      if (div_q == DIV_LAST) begin
        if (sx_q == H_LAST) begin
          sx_d = '0;
          sy_d = (sy_q == V_LAST) ? '0 : sy_q + CORDW'(1);
        end else begin
          sx_d = sx_q + CORDW'(1);
        end
      end
    end
  end

  // Sync windows decoded from the next position so they register with it.
  always_comb begin
    hs_act_d = (sx_d >= HS_LO) && (sx_d <= HS_HI);
    vs_act_d = (sy_d >= VS_LO) && (sy_d <= VS_HI);
  end

  // State and registered decoded outputs; reset wins on any edge.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      run_q    <= 1'b0;
      div_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      de_q     <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      pix_en_q <= 1'b0;
      hsync_q  <= ~HP;
      vsync_q  <= ~VP;
    end else begin
      run_q    <= 1'b1;
      div_q    <= div_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      de_q     <= (sx_d < H_ACT) && (sy_d < V_ACT);
      line_q   <= (sx_d == '0);
      frame_q  <= (sx_d == '0) && (sy_d == '0);
      pix_en_q <= (div_d == DIV_LAST);
      hsync_q  <= hs_act_d ? HP : ~HP;
      vsync_q  <= vs_act_d ? VP : ~VP;
    end
  end

  assign sx     = sx_q;
  assign sy     = sy_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign de     = de_q;
  assign pix_en = pix_en_q;
  assign line   = line_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: three instances (640x480 defaults, small
// mode, small mode with PIX_DIV=4) run against an arithmetic model that
// derives every output from the cycle count since reset release.
module tb_display_timing_gen;

  typedef struct {
    int hres, hfp, hsw, hbp, vres, vfp, vsw, vbp, hpol, vpol, div, cw;
  } cfg_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  always #5 clk = ~clk;

  logic [9:0] d_sx, d_sy;
  logic [3:0] a_sx, a_sy, b_sx, b_sy;
  logic d_hs, d_vs, d_de, d_pe, d_ln, d_fr;
  logic a_hs, a_vs, a_de, a_pe, a_ln, a_fr;
  logic b_hs, b_vs, b_de, b_pe, b_ln, b_fr;

  display_timing_gen u_def (
    .clk_pix(clk), .rst(rst_v[0]), .sx(d_sx), .sy(d_sy), .hsync(d_hs), .vsync(d_vs),
    .de(d_de), .pix_en(d_pe), .line(d_ln), .frame(d_fr));

  display_timing_gen #(.CORDW(4), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .PIX_DIV(1)) u_s1 (
    .clk_pix(clk), .rst(rst_v[1]), .sx(a_sx), .sy(a_sy), .hsync(a_hs), .vsync(a_vs),
    .de(a_de), .pix_en(a_pe), .line(a_ln), .frame(a_fr));

  display_timing_gen #(.CORDW(4), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .PIX_DIV(4)) u_s4 (
    .clk_pix(clk), .rst(rst_v[2]), .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs),
    .de(b_de), .pix_en(b_pe), .line(b_ln), .frame(b_fr));

  cfg_t  C [3];
  string NM [3];
  int    n_cmp = 0, n_bad = 0, cyc = 0;
  int    t [3], last_fr [3], last_ln [3], de_cnt [3];
  logic  prev_fr [3], prev_ln [3];

  // Expected outputs from cycle count t since release (t<0: held in reset).
  function automatic logic [37:0] model(input cfg_t c, input int tt);
    int ht, vt, p, x, y;
    logic hp, vp, hs, vs, de, pe;
    hp = (c.hpol != 0);
    vp = (c.vpol != 0);
    if (tt < 0) return {32'd0, ~hp, ~vp, 4'b0000};
    ht = c.hres + c.hfp + c.hsw + c.hbp;
    vt = c.vres + c.vfp + c.vsw + c.vbp;
    p  = tt / c.div;
    x  = p % ht;
    y  = (p / ht) % vt;
    hs = (x >= c.hres + c.hfp && x < c.hres + c.hfp + c.hsw) ? hp : ~hp;
    vs = (y >= c.vres + c.vfp && y < c.vres + c.vfp + c.vsw) ? vp : ~vp;
    de = (x < c.hres) && (y < c.vres);
    pe = ((tt % c.div) == c.div - 1);
    return {16'(x), 16'(y), hs, vs, de, pe, (x == 0), (x == 0 && y == 0)};
  endfunction

  function automatic logic [37:0] obs_of(input int i);
    case (i)
      0:       return {16'(d_sx), 16'(d_sy), d_hs, d_vs, d_de, d_pe, d_ln, d_fr};
      1:       return {16'(a_sx), 16'(a_sy), a_hs, a_vs, a_de, a_pe, a_ln, a_fr};
      default: return {16'(b_sx), 16'(b_sy), b_hs, b_vs, b_de, b_pe, b_ln, b_fr};
    endcase
  endfunction

  task automatic chk(input string nm, input string what, input logic [37:0] o, input logic [37:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s.%s @cyc %0d: observed %h expected %h", nm, what, cyc, o, e);
    end
  endtask

  // One clock: advance the model, then check every instance.
  task automatic step();
    logic [37:0] o, e;
    logic hp, vp, hsa, vsa;
    int ht, vt;
    @(posedge clk);
    for (int i = 0; i < 3; i++) t[i] = rst_v[i] ? -1 : ((t[i] < 0) ? 0 : t[i] + 1);
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      o  = obs_of(i);
      e  = model(C[i], t[i]);
      hp = (C[i].hpol != 0);
      vp = (C[i].vpol != 0);
      ht = C[i].hres + C[i].hfp + C[i].hsw + C[i].hbp;
      vt = C[i].vres + C[i].vfp + C[i].vsw + C[i].vbp;
      chk(NM[i], "state", o, e);
      if (t[i] < 0) begin
        last_fr[i] = -1; last_ln[i] = -1; de_cnt[i] = 0;
      end else begin
        hsa = (o[5] == hp);
        vsa = (o[4] == vp);
        chk(NM[i], "line_sx0", 38'(o[1]), 38'(o[37:22] == 16'd0));
        chk(NM[i], "frame_line", 38'(o[0] && !o[1]), 38'd0);
        chk(NM[i], "de_sync", 38'(o[3] && (hsa || vsa)), 38'd0);
        if (o[1] && !prev_ln[i]) begin
          if (last_ln[i] >= 0) chk(NM[i], "line_period", 38'(cyc - last_ln[i]), 38'(ht * C[i].div));
          last_ln[i] = cyc;
        end
        if (o[0] && !prev_fr[i]) begin
          if (last_fr[i] >= 0) begin
            chk(NM[i], "frame_period", 38'(cyc - last_fr[i]), 38'(ht * vt * C[i].div));
            chk(NM[i], "de_count", 38'(de_cnt[i]), 38'(C[i].hres * C[i].vres * C[i].div));
          end
          last_fr[i] = cyc;
          de_cnt[i]  = 0;
        end
        if (o[3]) de_cnt[i]++;
      end
      prev_ln[i] = o[1];
      prev_fr[i] = o[0];
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int ii, dly, hold;
    C[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 10};
    C[1] = '{8, 2, 3, 1, 4, 1, 1, 1, 1, 1, 1, 4};
    C[2] = '{8, 2, 3, 1, 4, 1, 1, 1, 1, 1, 4, 4};
    NM[0] = "def"; NM[1] = "s1"; NM[2] = "s4";
    for (int i = 0; i < 3; i++) begin
      t[i] = -1; last_fr[i] = -1; last_ln[i] = -1; de_cnt[i] = 0;
      prev_fr[i] = 1'b0; prev_ln[i] = 1'b0;
      if (C[i].hres + C[i].hfp + C[i].hsw + C[i].hbp - 1 >= (1 << C[i].cw) ||
          C[i].vres + C[i].vfp + C[i].vsw + C[i].vbp - 1 >= (1 << C[i].cw)) begin
        $display("FAIL %s.cordw: counter width too small for timing", NM[i]);
        $fatal(1, "illegal parameter set");
      end
    end

    // Reset held 5 cycles, then release everything together.
    rst_v = 3'b111;
    run(5);
    rst_v = 3'b000;
    run(1200 + int'($urandom_range(0, 400)));

    // Mid-frame reset on small mode at sx=11, sy=5 (both syncs active).
    for (int k = 0; k < 300 && !(t[1] >= 0 && (t[1] % 98) == 81); k++) step();
    chk("s1", "reach_11_5", 38'(t[1] % 98), 38'd81);
    rst_v[1] = 1'b1;
    run(1 + int'($urandom_range(0, 3)));
    rst_v[1] = 1'b0;
    run(300);

    // Randomised reset pulses on random instances at random times.
    for (int r = 0; r < 8; r++) begin
      ii   = int'($urandom_range(0, 2));
      dly  = int'($urandom_range(1, 200));
      hold = int'($urandom_range(1, 6));
      run(dly);
      rst_v[ii] = 1'b1;
      run(hold);
      rst_v[ii] = 1'b0;
    end

    run(6000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
